// File: rtl/pipelined_carry_skip_adder.sv
// Carry-skip adder split into STAGES pipeline segments behind a global valid/ready stall.
// Define PCSA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_carry_skip_adder #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PCSA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int NG = WIDTH / GROUP;

    // v_s/a_s/b_s/s_s/c_s[k] are the inputs seen by segment k
    logic             adv_s;
    logic             v_s [STAGES];
    logic [WIDTH-1:0] a_s [STAGES];
    logic [WIDTH-1:0] b_s [STAGES];
    logic [WIDTH-1:0] s_s [STAGES];
    logic             c_s [STAGES];

    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
`ifdef PCSA_OVF_EN
    logic             ovf_r;
`endif

    assign adv_s    = ~out_valid_r | out_ready;
    assign in_ready = adv_s;

    assign v_s[0] = in_valid;
    assign a_s[0] = a;
    assign b_s[0] = sub ? ~b : b;
    assign c_s[0] = sub ? 1'b1 : cin;
    assign s_s[0] = {WIDTH{1'b0}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = (k * NG) / STAGES;
        localparam int HI = ((k + 1) * NG) / STAGES;

        logic [WIDTH-1:0] seg_sum_s;
        logic             seg_cout_s;
        logic             run_c_s;
        logic             all_p_s;
        logic             bit_p_s;

        // Ripple inside each group of this segment; a fully propagating group passes its carry-in straight through.
        always_comb begin
            seg_sum_s  = s_s[k];
            seg_cout_s = c_s[k];
            run_c_s    = 1'b0;
            all_p_s    = 1'b0;
            bit_p_s    = 1'b0;
            for (int g = 0; g < NG; g++) begin
                if ((g >= LO) && (g < HI)) begin
                    run_c_s = seg_cout_s;
                    all_p_s = 1'b1;
                    for (int i = 0; i < GROUP; i++) begin
                        bit_p_s = a_s[k][g*GROUP+i] ^ b_s[k][g*GROUP+i];
                        seg_sum_s[g*GROUP+i] = bit_p_s ^ run_c_s;
                        run_c_s = (a_s[k][g*GROUP+i] & b_s[k][g*GROUP+i]) | (bit_p_s & run_c_s);
                        all_p_s = all_p_s & bit_p_s;
                    end
                    seg_cout_s = all_p_s ? seg_cout_s : run_c_s;
                end else begin
                    seg_cout_s = seg_cout_s;
                end
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic             v_r;
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;
            logic [WIDTH-1:0] s_r;
            logic             c_r;

            // Segment boundary register: operands still pending, partial sum and boundary carry.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r <= 1'b0;
                    a_r <= {WIDTH{1'b0}};
                    b_r <= {WIDTH{1'b0}};
                    s_r <= {WIDTH{1'b0}};
                    c_r <= 1'b0;
                end else if (adv_s) begin
                    v_r <= v_s[k];
                    if (v_s[k]) begin
                        a_r <= a_s[k];
                        b_r <= b_s[k];
                        s_r <= seg_sum_s;
                        c_r <= seg_cout_s;
                    end else begin
                        a_r <= a_r;
                        b_r <= b_r;
                        s_r <= s_r;
                        c_r <= c_r;
                    end
                end else begin
                    v_r <= v_r;
                    a_r <= a_r;
                    b_r <= b_r;
                    s_r <= s_r;
                    c_r <= c_r;
                end
            end

            assign v_s[k+1] = v_r;
            assign a_s[k+1] = a_r;
            assign b_s[k+1] = b_r;
            assign s_s[k+1] = s_r;
            assign c_s[k+1] = c_r;
        end else begin : g_last
            // Output register: result data only loads with a valid slot so it stays stable across bubbles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_r <= 1'b0;
                    sum_r       <= {WIDTH{1'b0}};
                    cout_r      <= 1'b0;
`ifdef PCSA_OVF_EN
                    ovf_r       <= 1'b0;
`endif
                end else if (adv_s) begin
                    out_valid_r <= v_s[k];
                    if (v_s[k]) begin
                        sum_r  <= seg_sum_s;
                        cout_r <= seg_cout_s;
`ifdef PCSA_OVF_EN
                        // carry into the MSB is recovered from its sum bit and operand bits
                        ovf_r  <= seg_sum_s[WIDTH-1] ^ a_s[k][WIDTH-1] ^ b_s[k][WIDTH-1] ^ seg_cout_s;
`endif
                    end else begin
                        sum_r  <= sum_r;
                        cout_r <= cout_r;
`ifdef PCSA_OVF_EN
                        ovf_r  <= ovf_r;
`endif
                    end
                end else begin
                    out_valid_r <= out_valid_r;
                    sum_r       <= sum_r;
                    cout_r      <= cout_r;
`ifdef PCSA_OVF_EN
                    ovf_r       <= ovf_r;
`endif
                end
            end
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
`ifdef PCSA_OVF_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: doc/pipelined_carry_skip_adder.md
PIPELINED_CARRY_SKIP_ADDER -- requirements
Module: pipelined_carry_skip_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits; a multiple of GROUP and at least 2*GROUP.
REQ-002 SHALL have parameter GROUP, default 4, meaning bits per skip group.
REQ-003 SHALL have parameter STAGES, default 2, meaning register stages (1..WIDTH/GROUP), equal to the latency.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand bundle valid.
REQ-007 in_ready  output  1  block accepts the bundle this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry in.
REQ-011 sub  input  1  1: compute a + ~b + 1 (cin ignored); 0: a + b + cin.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 sum  output  WIDTH  result bits.
REQ-015 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-016 Per-bit G=a&b', P=a^b' (b'=sub?~b:b); group carry-out SHALL be carry-in when all GROUP P bits are 1, else the ripple group generate.
REQ-017 {cout,sum} SHALL equal a + b' + (sub?1:cin) modulo 2^(WIDTH+1), bit-exact for all inputs.
REQ-018 Skip chain SHALL split into STAGES segments at group boundaries, segment k covering groups floor(k*NG/STAGES)..floor((k+1)*NG/STAGES)-1, NG=WIDTH/GROUP; pipeline registers between segments carry partial sum, pending operands and boundary carry.
REQ-019 Handshake: transfer occurs when valid&ready on the same edge; in_ready = !out_valid_final | out_ready, evaluated combinationally (global stall).
REQ-020 When stalled (out_valid & !out_ready) all stage registers and out_valid/sum/cout SHALL hold unchanged.
REQ-021 A bundle accepted on edge n SHALL appear on sum/cout with out_valid=1 after edge n+STAGES absent stalls; each stall cycle adds exactly one cycle.
REQ-022 Bundles SHALL emerge in acceptance order; none dropped or duplicated; bubbles (in_valid=0) propagate as invalid slots.
REQ-023 With out_ready held 1, throughput SHALL be one result per cycle.
REQ-024 Simultaneous accept and output in one cycle SHALL both occur (full pipeline streams).
REQ-025 sum/cout SHALL hold their last value while out_valid=0 after first result; content is don't-care but stable.

Reset
REQ-026 On rst=1 at a rising edge: all stage-valid bits, out_valid, sum, cout (and ovf) SHALL become 0.
REQ-027 rst mid-operation SHALL discard all in-flight bundles; no result of a bundle accepted before reset appears afterward.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts; rst has priority over handshake.

Configuration
REQ-029 Macro PCSA_OVF_EN defined: adds output ovf (1 bit) = signed two's-complement overflow (carry into MSB XOR cout), aligned with sum, reset 0, held on stall.
REQ-030 PCSA_OVF_EN undefined: no ovf port, no ovf logic; all other behaviour identical.

Verification
REQ-031 WIDTH=16,GROUP=4,STAGES=2: a=0xFFFF,b=0x0001,cin=0,sub=0 -> 2 cycles later sum=0x0000,cout=1 (full skip chain); ovf=0.
REQ-032 a=0x7FFF,b=0x0001,sub=0 -> sum=0x8000,cout=0,ovf=1; a=0x0005,b=0x0007,sub=1 -> sum=0xFFFE,cout=0.
REQ-033 Stream 100 random bundles with out_ready=1 -> 100 consecutive out_valid cycles, results match reference model in order.
REQ-034 out_ready=0 for 5 cycles with pipeline full -> in_ready=0, sum/cout/out_valid frozen; release -> results in order, none lost.
REQ-035 Assert rst with 2 bundles in flight -> next cycle out_valid=0, sum=0; neither bundle ever emerges.
REQ-036 Sweep STAGES=1 and STAGES=4 (WIDTH=16) with exhaustive 8-bit-boundary carry patterns -> latency equals STAGES, results bit-exact.
